// File: rtl/router_sync_n.sv
// router_sync_n: bridges the router input FSM to NUM_CH output FIFOs.
// Latches the packet destination, decodes one-hot FIFO write enables,
// returns the addressed FIFO's full flag, flags out-of-range addresses,
// and runs a per-channel watchdog that soft-resets FIFOs left unread.
module router_sync_n #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 30
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_en_reg,
  input  logic [NUM_CH-1:0] read_en,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] full,
  output logic [NUM_CH-1:0] write_en,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] valid_out,
  output logic [NUM_CH-1:0] soft_rst,
  output logic              addr_err
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  // One extra bit so NUM_CH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] CH_LIMIT = (ADDR_W + 1)'(NUM_CH);

  logic [ADDR_W-1:0] addr_reg;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] wait_v;

  // Destination register: captured on the address strobe, held otherwise.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      addr_reg <= '0;
    end else if (detect_add) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, independent of block ordering.
      addr_reg <= data_in;
    end
  end

  assign addr_err  = ({1'b0, addr_reg} >= CH_LIMIT);
  assign valid_out = ~empty;
  assign wait_v    = valid_out & ~read_en;

  // Decode the latched address into a write strobe and pick its full flag;
  // an out-of-range address selects nothing, so the payload is dropped.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    write_en  = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!addr_err && (addr_reg == ADDR_W'(i))) begin
        write_en[i] = write_en_reg;
        fifo_full   = full[i];
      end
    end
  end

  // Per-channel watchdog: count consecutive unread-valid cycles and fire a
  // one-cycle soft reset on the TIMEOUT-th, then start counting again.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      // NOTE: the counter array is a few flops, not RAM, so it is reset
      // along with the rest of the state.
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      soft_rst <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!wait_v[i]) begin
          cnt[i]      <= '0;
          soft_rst[i] <= 1'b0;
        end else if (cnt[i] == CNT_MAX) begin
          cnt[i]      <= '0;
          soft_rst[i] <= 1'b1;
        end else begin
          cnt[i]      <= cnt[i] + CNT_W'(1);
          soft_rst[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/router_sync_n.md
Name: router_sync_n

Overview:
Parametrised synchroniser between the router's input FSM/register block and NUM_CH output FIFOs. It latches the destination address of each packet and decodes it into one-hot FIFO write enables. It multiplexes the selected FIFO's full flag back to the FSM and presents per-channel valid_out flags. Per-channel watchdog counters issue a one-cycle soft reset to any FIFO whose data sits unread for TIMEOUT cycles. This generation adds channel-count and timeout parametrisation, plus out-of-range address detection (addr_err) with write suppression.

Parameters:
NUM_CH, 3, number of output channels/FIFOs (2..16).
ADDR_W, 2, width of address field on data_in; 2**ADDR_W >= NUM_CH required.
TIMEOUT, 30, consecutive unread-valid cycles before soft reset (>= 2).

Ports:
clk  in  1  clock; all state updates on rising edge.
reset_in  in  1  asynchronous active-low reset.
detect_add  in  1  address phase strobe from FSM.
data_in  in  ADDR_W  destination address, sampled when detect_add=1.
write_en_reg  in  1  payload write request from FSM.
read_en  in  NUM_CH  per-channel FIFO read enable from output side; bit i = channel i.
empty  in  NUM_CH  per-channel FIFO empty flags.
full  in  NUM_CH  per-channel FIFO full flags.
write_en  out  NUM_CH  one-hot FIFO write enable.
fifo_full  out  1  full flag of currently addressed FIFO.
valid_out  out  NUM_CH  per-channel data-available flag.
soft_rst  out  NUM_CH  per-channel one-cycle FIFO soft reset.
addr_err  out  1  latched address is >= NUM_CH.

Behaviour:
- Reset, asynchronous on reset_in=0 and effective without a clock edge:
  - addr_reg=0, all watchdog counters=0, soft_rst=0.
  - Combinational outputs follow from the reset state: addr_err=0, write_en=0 if write_en_reg=0.
- addr_reg:
  - Loads data_in on a rising edge with detect_add=1; otherwise holds.
  - A change takes effect the cycle after the strobe.
  - If detect_add and write_en_reg are high in the same cycle, write_en decodes the OLD addr_reg.
- addr_err = (addr_reg >= NUM_CH). Combinational from the register.
- write_en (combinational, zero latency):
  - write_en[addr_reg] = write_en_reg when addr_err=0; all other bits 0.
  - When addr_err=1, write_en = 0 and payload is silently dropped.
- fifo_full (combinational): full[addr_reg] when addr_err=0; 0 when addr_err=1, so the FSM never stalls on a dropped packet.
- valid_out[i] = ~empty[i] (combinational).
- Watchdog, channel i, independent per channel:
  - cnt_i has width $clog2(TIMEOUT).
  - wait_i = valid_out[i] & ~read_en[i].
  - If wait_i=0: cnt_i <= 0, soft_rst[i] <= 0.
  - If wait_i=1 and cnt_i < TIMEOUT-1: cnt_i <= cnt_i+1, soft_rst[i] <= 0.
  - If wait_i=1 and cnt_i == TIMEOUT-1: soft_rst[i] <= 1, cnt_i <= 0.
  - Result: soft_rst[i] rises at the TIMEOUT-th consecutive waiting edge and is high exactly one cycle. If the FIFO does not empty, the count restarts and repeats every TIMEOUT cycles.
  - A single read_en[i] cycle anywhere clears the count; there is no wrap-around overflow.
- Multiple channels may assert soft_rst in the same cycle.
- The watchdog is independent of addr_reg and of addr_err.

Test Plan:
1. Reset: drive reset_in=0 mid-count with clk stopped → soft_rst=000, addr_err=0, write_en=000 immediately. Release → counters restart from 0.
2. Address/write: detect_add=1, data_in=2; next cycle write_en_reg=1 → write_en=3'b100. full=3'b100 → fifo_full=1; full=3'b001 → fifo_full=0. Same-cycle detect_add(data_in=0)+write_en_reg → write_en=3'b100, then 3'b001 on the following cycle.
3. Invalid address: detect_add, data_in=3 → addr_err=1; write_en_reg=1 → write_en=000, fifo_full=0 even with full=3'b111. Next detect_add with data_in=1 → addr_err=0.
4. Timeout: empty[0]=0, read_en[0]=0 held → soft_rst[0]=1 for exactly one cycle, 30 edges after empty[0] falls. Held longer → second pulse 30 cycles later.
5. Near-miss: read_en[0]=1 for one cycle at the 29th waiting cycle → no pulse. Next soft_rst[0] comes 30 waiting cycles after the read.
6. Concurrency: channels 1 and 2 start waiting 5 cycles apart → soft_rst[1] and soft_rst[2] pulse 5 cycles apart, channel 0 unaffected. Repeat with NUM_CH=4, ADDR_W=2, TIMEOUT=8 → data_in=3 gives write_en=4'b1000, pulses after 8 cycles.
